// File: rtl/psram_pkg.sv
// Shared types and constants for the PSRAM arbiter slice.
// Build with PSRAM_ARB_TIMEOUT_EN to enable the transaction watchdog.
package psram_pkg;

  localparam int PSRAM_AW = 24;
  localparam int PSRAM_DW = 16;

  localparam logic [PSRAM_DW-1:0] TIMEOUT_RDATA = 16'hDEAD;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } ArbState_t;

endpackage

// File: rtl/psram_rr_pick.sv
// Combinational round-robin picker: search starts one past ptr and wraps.
// Yields a one-hot grant plus the winner index.
import psram_pkg::*;

module psram_rr_pick #(
  parameter int N_REQ = 2,
  parameter int IW    = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    idx
);

  logic          found;
  logic [IW-1:0] k;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = IW'((int'(ptr) + i) % N_REQ);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/psram_arbiter.sv
// Round-robin arbiter/sequencer sharing one PSRAM controller port.
// Optional watchdog: define PSRAM_ARB_TIMEOUT_EN.
import psram_pkg::*;

module psram_arbiter #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      arst_n,
  input  logic                      i_clk,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_req_we,
  input  logic [N_REQ*PSRAM_AW-1:0] i_req_addr,
  input  logic [N_REQ*PSRAM_DW-1:0] i_req_wdata,
  output logic [N_REQ-1:0]          o_ack,
  output logic [PSRAM_DW-1:0]       o_rdata,
  output logic [N_REQ-1:0]          o_gnt,
  output logic                      o_ready,
  output logic                      o_psram_stb,
  output logic                      o_psram_we,
  output logic [PSRAM_AW-1:0]       o_psram_addr,
  output logic [PSRAM_DW-1:0]       o_psram_din,
  input  logic                      i_psram_busy,
  input  logic                      i_psram_done,
  input  logic [PSRAM_DW-1:0]       i_psram_dout,
  output logic                      o_err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  ArbState_t      state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  pick_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic           rdy;
  logic           tmo;

  // Busy alone drops before init finishes, so done must be seen too
  assign rdy = i_psram_done & ~i_psram_busy;

  psram_rr_pick #(
    .N_REQ(N_REQ),
    .IW   (IW)
  ) u_pick (
    .req(i_req),
    .ptr(ptr),
    .gnt(pick_gnt),
    .idx(pick_idx)
  );

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  assign tmo = ((state == WAIT_ACK) || (state == WAIT_DONE))
             && (cnt == CW'(TIMEOUT_CYC - 1));
  assign o_err = err_q;

  always_ff @(posedge i_clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      if ((state == WAIT_ACK) || (state == WAIT_DONE))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
      if (tmo)
        err_q <= 1'b1;
    end
  end
`else
  assign tmo   = 1'b0;
  assign o_err = 1'b0;

  if (TIMEOUT_CYC < 1) begin : g_no_wdog
  end
`endif

  always_ff @(posedge i_clk or negedge arst_n) begin
    if (!arst_n) begin
      state        <= INIT;
      ptr          <= IW'(N_REQ - 1);
      o_gnt        <= '0;
      o_ack        <= '0;
      o_rdata      <= '0;
      o_ready      <= 1'b0;
      o_psram_stb  <= 1'b0;
      o_psram_we   <= 1'b0;
      o_psram_addr <= '0;
      o_psram_din  <= '0;
    end else begin
      o_ack       <= '0;
      o_psram_stb <= 1'b0;
      if (tmo) begin
        o_rdata <= TIMEOUT_RDATA;
        o_ack   <= o_gnt;
        state   <= RESP;
      end else begin
        unique case (state)
          INIT: begin
            if (rdy) begin
              o_ready <= 1'b1;
              state   <= IDLE;
            end
          end
          IDLE: begin
            if ((|i_req) && rdy) begin
              o_gnt        <= pick_gnt;
              ptr          <= pick_idx;
              o_psram_we   <= i_req_we[pick_idx];
              o_psram_addr <= i_req_addr[int'(pick_idx)*PSRAM_AW +: PSRAM_AW];
              o_psram_din  <= i_req_wdata[int'(pick_idx)*PSRAM_DW +: PSRAM_DW];
              o_psram_stb  <= 1'b1;
              state        <= ISSUE;
            end
          end
          ISSUE: state <= WAIT_ACK;
          WAIT_ACK: begin
            if (i_psram_busy || !i_psram_done)
              state <= WAIT_DONE;
          end
          WAIT_DONE: begin
            if (i_psram_done) begin
              if (!o_psram_we)
                o_rdata <= i_psram_dout;
              o_ack <= o_gnt;
              state <= RESP;
            end
          end
          RESP: begin
            o_gnt <= '0;
            state <= IDLE;
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Directed bench for psram_arbiter with a small behavioural controller.
// Timeout vectors run only when PSRAM_ARB_TIMEOUT_EN is defined.
module tb_psram_arbiter;

  logic        clk = 1'b0;
  logic        arst_n;
  logic [1:0]  req, req_we;
  logic [47:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  ack, gnt;
  logic [15:0] rdata;
  logic        ready, stb, p_we, err;
  logic [23:0] p_addr;
  logic [15:0] p_din;
  logic        busy_m, done_m;
  logic [15:0] dout_m;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          init_ok;
  bit          hang;
  logic [15:0] model_rdata;
  int          mcnt;

  int          stb_cnt = 0;
  int          stb_dbl = 0;
  int          ack_cnt = 0;
  int          stab_bad = 0;
  logic        prev_stb = 1'b0;
  logic [23:0] cap_addr;
  logic [15:0] cap_din;
  logic        cap_we;

  always #5 clk = ~clk;

  psram_arbiter #(.N_REQ(2), .TIMEOUT_CYC(64)) dut (
    .arst_n      (arst_n),
    .i_clk       (clk),
    .i_req       (req),
    .i_req_we    (req_we),
    .i_req_addr  (req_addr),
    .i_req_wdata (req_wdata),
    .o_ack       (ack),
    .o_rdata     (rdata),
    .o_gnt       (gnt),
    .o_ready     (ready),
    .o_psram_stb (stb),
    .o_psram_we  (p_we),
    .o_psram_addr(p_addr),
    .o_psram_din (p_din),
    .i_psram_busy(busy_m),
    .i_psram_done(done_m),
    .i_psram_dout(dout_m),
    .o_err       (err)
  );

  // Controller: done low until init_ok, then 3 busy cycles per strobe
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      busy_m <= 1'b0;
      done_m <= 1'b0;
      dout_m <= '0;
      mcnt   <= 0;
    end else if (!init_ok) begin
      busy_m <= 1'b0;
      done_m <= 1'b0;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1 && !hang) begin
        done_m <= 1'b1;
        busy_m <= 1'b0;
        dout_m <= model_rdata;
      end
    end else if (stb) begin
      busy_m <= 1'b1;
      done_m <= 1'b0;
      mcnt   <= 3;
    end else if (!busy_m) begin
      done_m <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (stb) begin
      stb_cnt++;
      if (prev_stb) stb_dbl++;
      cap_addr = p_addr;
      cap_din  = p_din;
      cap_we   = p_we;
    end else if (gnt != 2'b00) begin
      if (p_addr != cap_addr || p_din != cap_din || p_we != cap_we)
        stab_bad++;
    end
    prev_stb = stb;
    if (ack != 2'b00) ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_stb(input string tag, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!stb && cyc < max);
    check(tag, 32'(stb), 32'd1);
  endtask

  task automatic wait_ack(input string tag, input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack == 2'b00 && cyc < max);
    check(tag, 32'(ack != 2'b00), 32'd1);
  endtask

  int cyc;
  int k;
  int acks0;
  logic [1:0] order [6];

  initial begin
    arst_n      = 1'b0;
    init_ok     = 1'b0;
    hang        = 1'b0;
    model_rdata = 16'h0000;
    req         = 2'b00;
    req_we      = 2'b00;
    req_addr    = '0;
    req_wdata   = '0;
    repeat (3) @(negedge clk);

    check("rst_ack",   32'(ack),   32'd0);
    check("rst_gnt",   32'(gnt),   32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_stb",   32'(stb),   32'd0);
    check("rst_addr",  32'(p_addr), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_err",   32'(err),   32'd0);

    arst_n = 1'b1;
    req    = 2'b01;
    req_we = 2'b01;
    req_addr[23:0]  = 24'h000123;
    req_wdata[15:0] = 16'hA5C3;
    repeat (20000) @(negedge clk);
    check("gate_stb",   32'(stb_cnt), 32'd0);
    check("gate_ready", 32'(ready),   32'd0);

    init_ok = 1'b1;
    wait_stb("init_stb", 6, cyc);
    check("init_ready", 32'(ready),  32'd1);
    check("wr_gnt",     32'(gnt),    32'h1);
    check("wr_addr",    32'(p_addr), 32'h000123);
    check("wr_we",      32'(p_we),   32'd1);
    check("wr_din",     32'(p_din),  32'hA5C3);
    wait_ack("wr_ack_seen", 50, cyc);
    check("wr_ack",    32'(ack),     32'h1);
    check("wr_stbcnt", 32'(stb_cnt), 32'd1);
    check("wr_addr_r", 32'(p_addr),  32'h000123);
    req = 2'b00;
    @(negedge clk);
    check("wr_ack_1cyc", 32'(ack), 32'd0);
    check("wr_gnt_clr",  32'(gnt), 32'd0);
    repeat (2) @(negedge clk);

    req_we[1]        = 1'b0;
    req_addr[47:24]  = 24'h0ABCDE;
    model_rdata      = 16'h1234;
    req              = 2'b10;
    wait_stb("rd_stb", 6, cyc);
    check("rd_gnt",  32'(gnt),    32'h2);
    check("rd_addr", 32'(p_addr), 32'h0ABCDE);
    check("rd_we",   32'(p_we),   32'd0);
    @(negedge clk);
    req_addr[47:24] = 24'hFFFFFF;
    check("rd_gnt_mid", 32'(gnt), 32'h2);
    wait_ack("rd_ack_seen", 50, cyc);
    check("rd_ack",    32'(ack),    32'h2);
    check("rd_data",   32'(rdata),  32'h1234);
    check("rd_stable", 32'(p_addr), 32'h0ABCDE);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("rd_hold", 32'(rdata), 32'h1234);

    req_we    = 2'b11;
    req_addr  = {24'h000020, 24'h000010};
    req_wdata = {16'h2222, 16'h1111};
    req       = 2'b11;
    for (int i = 0; i < 6; i++) begin
      wait_ack("rr_ack_seen", 50, cyc);
      order[i] = ack;
      check($sformatf("rr_order%0d", i), 32'(ack),
            (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i < 5) begin
        wait_stb("rr_stb", 6, cyc);
        check($sformatf("rr_gap%0d", i), 32'(cyc), 32'd2);
        check($sformatf("rr_addr%0d", i), 32'(p_addr),
              (i % 2 == 0) ? 32'h20 : 32'h10);
      end
    end
    req = 2'b00;
    @(negedge clk);
    check("rr_rdata_keep", 32'(rdata), 32'h1234);
    check("stb_single",    32'(stb_dbl),  32'd0);
    check("stability",     32'(stab_bad), 32'd0);
    repeat (2) @(negedge clk);

    req_we[0]      = 1'b0;
    req_addr[23:0] = 24'h000777;
    model_rdata    = 16'h5A5A;
    req            = 2'b01;
    wait_stb("mid_stb", 6, cyc);
    repeat (2) @(negedge clk);
    acks0   = ack_cnt;
    init_ok = 1'b0;
    arst_n  = 1'b0;
    #1;
    check("mid_ack",   32'(ack),    32'd0);
    check("mid_gnt",   32'(gnt),    32'd0);
    check("mid_ready", 32'(ready),  32'd0);
    check("mid_stb",   32'(stb),    32'd0);
    check("mid_addr",  32'(p_addr), 32'd0);
    check("mid_rdata", 32'(rdata),  32'd0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_no_ack",   32'(ack_cnt - acks0), 32'd0);
    check("mid_reinit",   32'(ready), 32'd0);
    init_ok = 1'b1;
    wait_ack("mid_ack_seen", 50, cyc);
    check("mid_rd_ack",   32'(ack),   32'h1);
    check("mid_rd_data",  32'(rdata), 32'h5A5A);
    req = 2'b00;
    repeat (2) @(negedge clk);

`ifdef PSRAM_ARB_TIMEOUT_EN
    hang           = 1'b1;
    req_addr[23:0] = 24'h000042;
    req            = 2'b01;
    wait_stb("to_stb", 6, cyc);
    wait_ack("to_ack_seen", 200, cyc);
    check("to_ack",   32'(ack),   32'h1);
    check("to_rdata", 32'(rdata), 32'hDEAD);
    check("to_err",   32'(err),   32'd1);
    check("to_delay", 32'(cyc >= 64), 32'd1);
    req = 2'b00;
    repeat (3) @(negedge clk);
    check("to_sticky", 32'(err), 32'd1);
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
